// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer for the single-port, word-addressed data memory.
// Handles sub-word extraction and extension, read-modify-write sub-word stores,
// and alignment errors.
module dmem_access_ctrl #(
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              mem_store,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] WaitLast = 4'(READ_WAIT);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        write_q;
  logic [15:0] wdata_q;
  logic [3:0]  wait_q;

  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_result;
  logic [31:0] merged_word;
  logic [4:0]  lane_shift;

  assign req_ready = (state_q == StIdle);
  assign mem_store = (state_q == StWrite) && !reset;

  assign req_err = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  assign lane_shift = {lane_q, 3'b000};

  always_comb begin
    rd_byte = mem_rdata[7:0];
    unique case (lane_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    // Half accesses reaching here are aligned, so lane[1] selects the half.
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_result = mem_rdata;
    merged_word = mem_rdata;
    unique case (size_q)
      2'd0: begin
        load_result = unsigned_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        merged_word = (mem_rdata & ~(32'h0000_00ff << lane_shift)) |
                      ({24'h0, wdata_q[7:0]} << lane_shift);
      end
      2'd1: begin
        load_result = unsigned_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        merged_word = (mem_rdata & ~(32'h0000_ffff << lane_shift)) |
                      ({16'h0, wdata_q} << lane_shift);
      end
      default: begin
        load_result = mem_rdata;
        merged_word = mem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= 16'h0;
      wait_q      <= 4'd0;
      resp_valid  <= 1'b0;
      resp_error  <= 1'b0;
      resp_rdata  <= 32'h0;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            lane_q      <= req_addr[1:0];
            size_q      <= req_size;
            unsigned_q  <= req_unsigned;
            write_q     <= req_write;
            wdata_q     <= req_wdata[15:0];
            mem_address <= 32'(req_addr[ADDR_W-1:2]);
            if (req_err) begin
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end else if (req_write && req_size == 2'd2) begin
              mem_wdata <= req_wdata;
              state_q   <= StWrite;
            end else begin
              wait_q  <= 4'd1;
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (wait_q == WaitLast) begin
            if (write_q) begin
              mem_wdata <= merged_word;
              state_q   <= StWrite;
            end else begin
              resp_rdata <= load_result;
              resp_error <= 1'b0;
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        StWrite: begin
          resp_rdata <= 32'h0;
          resp_error <= 1'b0;
          resp_valid <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small behavioural data memory.
// Latency is counted as response cycles after the accept edge (error = 1).
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_store;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:15];
  int          store_cnt = 0;
  logic [31:0] last_st_addr = 32'h0;
  logic [31:0] last_st_data = 32'h0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_data = 32'h0;

  dmem_access_ctrl #(.READ_WAIT(1), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_store    (mem_store),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address[3:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_store) begin
      mem[mem_address[3:0]] <= mem_wdata;
      store_cnt    <= store_cnt + 1;
      last_st_addr <= mem_address;
      last_st_data <= mem_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    int guard = 0;
    while (!req_ready && guard < 100) begin
      tick;
      guard++;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      tick;
      cyc++;
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int cyc, output logic [31:0] rd, output logic er);
    drive_req(wr, sz, uns, addr, wd);
    wait_resp(cyc);
    rd = resp_rdata;
    er = resp_error;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    vectors++;
    if (mem_store !== 1'b0) begin
      miscompares++; $display("FAIL rst_mem_store_during got %b want 0", mem_store);
    end
    reset = 1'b0;
    tick;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flags got ready=%b valid=%b err=%b want 1/0/0",
               req_ready, resp_valid, resp_error);
    end
    vectors++;
    if (resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_data got rdata=%h addr=%h wdata=%h want 0/0/0",
               resp_rdata, mem_address, mem_wdata);
    end
  endtask

  task automatic test_loads;
    int c; logic [31:0] r; logic e;
    preload(4'd0, 32'h0000_4430);
    preload(4'd1, 32'h0000_8610);
    do_req(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'h0000_0044 || e !== 1'b0 || c != 2) begin
      miscompares++;
      $display("FAIL ld_byte1 got %h err=%b lat=%0d want 00000044 err=0 lat=2", r, e, c);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'hFFFF_8610 || e !== 1'b0) begin
      miscompares++; $display("FAIL ld_half4_s got %h err=%b want ffff8610 err=0", r, e);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'h0000_8610) begin
      miscompares++; $display("FAIL ld_half4_u got %h want 00008610", r);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'hFFFF_FF86) begin
      miscompares++; $display("FAIL ld_byte5_s got %h want ffffff86", r);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'h0000_0086) begin
      miscompares++; $display("FAIL ld_byte5_u got %h want 00000086", r);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'h0000_8610 || mem_address !== 32'h1) begin
      miscompares++;
      $display("FAIL ld_word4 got %h addr=%h want 00008610 addr=1", r, mem_address);
    end
  endtask

  task automatic test_subword_store;
    int c; int n0; logic [31:0] r; logic e;
    n0 = store_cnt;
    do_req(1'b1, 2'd0, 1'b0, 32'h2, 32'h0000_00AB, c, r, e);
    vectors++;
    if (store_cnt - n0 != 1 || last_st_addr !== 32'h0 || last_st_data !== 32'h00AB_4430) begin
      miscompares++;
      $display("FAIL st_byte2 got n=%0d addr=%h data=%h want 1/0/00ab4430",
               store_cnt - n0, last_st_addr, last_st_data);
    end
    vectors++;
    if (c != 3 || r !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL st_byte2_resp got lat=%0d rdata=%h err=%b want 3/0/0", c, r, e);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'h00AB_4430) begin
      miscompares++; $display("FAIL st_byte2_readback got %h want 00ab4430", r);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h1234_BEEF, c, r, e);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'hBEEF_8610) begin
      miscompares++; $display("FAIL st_half6_readback got %h want beef8610", r);
    end
  endtask

  task automatic test_errors;
    int c; int n0; logic [31:0] r; logic e;
    n0 = store_cnt;
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, c, r, e);
    vectors++;
    if (e !== 1'b1 || r !== 32'h0 || c != 1) begin
      miscompares++;
      $display("FAIL err_word6 got err=%b rdata=%h lat=%0d want 1/0/1", e, r, c);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, c, r, e);
    vectors++;
    if (e !== 1'b1 || r !== 32'h0 || c != 1) begin
      miscompares++;
      $display("FAIL err_half3 got err=%b rdata=%h lat=%0d want 1/0/1", e, r, c);
    end
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, c, r, e);
    vectors++;
    if (e !== 1'b1 || c != 1) begin
      miscompares++; $display("FAIL err_size3 got err=%b lat=%0d want 1/1", e, c);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'hDEAD_BEEF, c, r, e);
    vectors++;
    if (e !== 1'b1 || store_cnt != n0) begin
      miscompares++;
      $display("FAIL err_store_word2 got err=%b stores=%0d want 1/0", e, store_cnt - n0);
    end
  endtask

  task automatic test_backpressure;
    int c; int n0; logic [31:0] r; logic e;
    int bad = 0;
    n0 = store_cnt;
    drive_req(1'b1, 2'd2, 1'b0, 32'hC, 32'h0000_0193);
    wait_resp(c);
    vectors++;
    if (c != 2) begin
      miscompares++; $display("FAIL bp_latency got %0d want 2", c);
    end
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'h0 ||
          mem_address !== 32'h3) bad++;
      tick;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    vectors++;
    if (store_cnt - n0 != 1 || mem[3] !== 32'h0000_0193) begin
      miscompares++;
      $display("FAIL bp_store got n=%0d mem3=%h want 1/00000193", store_cnt - n0, mem[3]);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    r = resp_rdata; e = resp_error;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_back_to_back;
    int c; logic [31:0] r; logic e;
    do_req(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, c, r, e);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_ready got %b want 1", req_ready);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h2, 32'h0, c, r, e);
    vectors++;
    if (r !== 32'h0000_00AB || c != 2) begin
      miscompares++; $display("FAIL b2b_second got %h lat=%0d want 000000ab lat=2", r, c);
    end
  endtask

  task automatic test_reset_abort;
    int n0;
    logic [31:0] w0;
    n0 = store_cnt;
    w0 = mem[0];
    drive_req(1'b1, 2'd0, 1'b0, 32'h0, 32'h0000_0055);
    tick;
    vectors++;
    if (mem_store !== 1'b1) begin
      miscompares++; $display("FAIL abort_in_write got mem_store=%b want 1", mem_store);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_store !== 1'b0) begin
      miscompares++; $display("FAIL abort_store_gated got %b want 0", mem_store);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (store_cnt != n0 || mem[0] !== w0) begin
      miscompares++;
      $display("FAIL abort_mem got n=%0d word0=%h want 0/%h", store_cnt - n0, mem[0], w0);
    end
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_state got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
    tick;
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_resp got %b want 0", resp_valid);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_subword_store;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences all core load/store traffic into the single-port word-addressed data memory of the multi-cycle processor. Accepts one byte/half/word request at a time over a valid/ready handshake. Converts byte addresses to word indices and performs sub-word extraction with sign/zero extension. Sub-word stores use read-modify-write. Returns each result, or an alignment error, over a valid/ready response channel.

Parameters:
READ_WAIT, 1, cycles in READ before mem_rdata is sampled (1..15)
ADDR_W, 32, width of request byte address

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (IDLE only)
req_write  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
req_unsigned  in  1  zero-extend loads when 1
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  32  load result (0 for stores/errors)
resp_error  out  1  misaligned or reserved size
mem_store  out  1  write strobe to data memory
mem_address  out  32  word index = {2'b00, addr[31:2]}
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Clock clk; reset synchronous, active-high. Reset: state IDLE, resp_valid=0, resp_error=0, resp_rdata=0, mem_address=0, mem_wdata=0, wait counter=0.
- mem_store = (state==WRITE) && !reset; no write occurs on the edge where reset is high.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, size, unsigned, write, and wdata.
  - Error if size==3, size==1 && addr[0], or size==2 && addr[1:0]!=0. Go to RESP, resp_error=1, rdata=0. No memory access.
  - Word store goes to WRITE, with mem_wdata=req_wdata.
  - Load or sub-word store goes to READ.
- READ: mem_address held. Counter runs 1..READ_WAIT. On the last cycle, sample mem_rdata.
  - Load: lane=addr[1:0], little-endian (byte k = bits 8k+7:8k). Byte takes lane k, half takes bytes {k+1,k}, word is unchanged. Sign-extend unless unsigned. Result goes to resp_rdata; next state RESP.
  - Store: merge wdata low byte or half into the sampled word at the lane. Result goes to mem_wdata; next state WRITE.
- WRITE: one cycle, mem_store=1, then RESP with resp_rdata=0, resp_error=0.
- RESP: resp_valid=1. Outputs stay stable until resp_ready. On the handshake cycle go to IDLE; the next request is accepted one cycle later.
- Latency from the accept edge T to the first resp_valid cycle:
  - Error: T+1.
  - Word store: T+2.
  - Load: T+READ_WAIT+1.
  - Sub-word store: T+READ_WAIT+2.
- mem_address is stable from the cycle after accept through RESP. It changes only on accept or reset.
- req_valid in non-IDLE states is ignored (req_ready=0). Requesters must hold their request.
- Reset mid-operation aborts: no write is committed and the pending response is discarded. Memory contents are untouched except by WRITE cycles already completed.
- Address bits above the memory depth are passed through; truncation is memory-side.

Test Plan:
- Memory word0=0x00004430. Load byte addr 0x1, signed -> resp_rdata=0x00000044, error=0, resp_valid at T+2 (READ_WAIT=1).
- Memory word1=0x00008610. Load half addr 0x4 signed -> 0xFFFF8610. Same with unsigned=1 -> 0x00008610.
- Store byte 0x000000AB at addr 0x2 (word0=0x00004430) -> one mem_store pulse with mem_address=0, mem_wdata=0x00AB4430. Then load word addr 0x0 -> 0x00AB4430.
- Load word addr 0x6 and half addr 0x3 -> resp_error=1, rdata=0, mem_store never asserted, resp at T+1. Size=3 at addr 0x0 -> error.
- Store word 0x00000193 at addr 0xC with resp_ready held low 5 cycles -> single mem_store pulse (mem_address=3), resp_valid held stable, req_ready=0 until the handshake.
- Assert reset during the WRITE cycle of a byte store to addr 0x0 -> mem_store=0 on that edge, word0 unchanged, state IDLE, resp_valid=0 next cycle.
